// File: rtl/debug_op_sequencer.sv
// CPU-side debug operation sequencer: accepts a held DEBUG_REQ, performs STEP / MEM_RD /
// MEM_WR / RUN against the core and memory bus, and answers with a one-cycle DEBUG_ACK.
module debug_op_sequencer #(
    parameter int AW            = 16,
    parameter int DW            = 16,
    parameter int MEM_LATENCY   = 1,
    parameter bit HALT_ON_RESET = 1'b1,
    parameter int TIMEOUT       = 255
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          DEBUG_REQ,
    input  logic [1:0]    DEBUGX,
    input  logic          DEBUG_OP_INCX,
    output logic          DEBUG_ACK,
    output logic          DEBUG_ERR,
    input  logic          ERR_CLR,
    input  logic          ADDR_LD,
    input  logic [AW-1:0] ADDR_IN,
    input  logic [DW-1:0] WR_DATA,
    output logic [DW-1:0] RD_DATA,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_DOUT,
    input  logic [DW-1:0] MEM_DIN,
    output logic          MEM_RD,
    output logic          MEM_WR,
    output logic          CPU_HALT,
    input  logic          CPU_HALTED,
    output logic          CPU_STEP,
    input  logic          CPU_STEP_DONE
);

    typedef enum logic [2:0] {IDLE, HALTW, STEP, STEPW, MRD, MWR, ACK, DROP} state_t;

    localparam logic [1:0] OP_STEP = 2'b00;
    localparam logic [1:0] OP_MRD  = 2'b01;
    localparam logic [1:0] OP_MWR  = 2'b10;
    localparam logic [1:0] OP_RUN  = 2'b11;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] LAT_LAST = 8'(MEM_LATENCY - 1);

    state_t          state, state_next;
    logic [7:0]      cnt;
    logic [1:0]      op;
    logic            incx;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   rd_data;
    logic            halt;
    logic            err;
    logic            accept, tmo_hit, rd_last, mem_done, addr_ld_ok;

    assign accept     = (state == IDLE) && DEBUG_REQ;
    assign tmo_hit    = (cnt == TMO_LAST) &&
                        (((state == HALTW) && !CPU_HALTED) ||
                         ((state == STEPW) && !CPU_STEP_DONE));
    assign rd_last    = (state == MRD) && (cnt == LAT_LAST);
    assign mem_done   = rd_last || (state == MWR);
    assign addr_ld_ok = ADDR_LD && ((state == IDLE) || (state == DROP));

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (DEBUG_REQ) state_next = (DEBUGX == OP_RUN) ? ACK : HALTW;
            HALTW: begin
                if (CPU_HALTED) begin
                    case (op)
                        OP_STEP: state_next = STEP;
                        OP_MRD:  state_next = MRD;
                        OP_MWR:  state_next = MWR;
                        default: state_next = ACK;
                    endcase
                end else if (tmo_hit) begin
                    state_next = ACK;
                end
            end
            STEP:  state_next = STEPW;
            STEPW: if (CPU_STEP_DONE || tmo_hit) state_next = ACK;
            MRD:   if (rd_last) state_next = ACK;
            MWR:   state_next = ACK;
            ACK:   state_next = DROP;
            DROP:  if (!DEBUG_REQ) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        DEBUG_ACK = 1'b0;
        MEM_RD    = 1'b0;
        MEM_WR    = 1'b0;
        MEM_DOUT  = '0;
        CPU_STEP  = 1'b0;
        case (state)
            STEP: CPU_STEP  = 1'b1;
            MRD:  MEM_RD    = 1'b1;
            MWR:  begin
                MEM_WR   = 1'b1;
                MEM_DOUT = WR_DATA;
            end
            ACK:  DEBUG_ACK = 1'b1;
            default: ;
        endcase
    end

    // cnt restarts on every state change, so it measures dwell time in the current state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt     <= '0;
            halt    <= HALT_ON_RESET;
            err     <= 1'b0;
            rd_data <= '0;
            addr    <= '0;
        end else begin
            cnt <= (state_next != state) ? 8'd0 : cnt + 8'd1;
            if (accept)       halt <= (DEBUGX != OP_RUN);
            if (tmo_hit)      err  <= 1'b1;
            else if (ERR_CLR) err  <= 1'b0;
            if (rd_last)      rd_data <= MEM_DIN;
            if (addr_ld_ok)             addr <= ADDR_IN;
            else if (mem_done && incx)  addr <= addr + AW'(1);
        end
    end

    // Operation and increment flag are frozen at acceptance
    always_ff @(posedge CLK) begin
        if (accept) begin
            op   <= DEBUGX;
            incx <= DEBUG_OP_INCX;
        end
    end

    assign DEBUG_ERR = err;
    assign RD_DATA   = rd_data;
    assign MEM_ADDR  = addr;
    assign CPU_HALT  = halt;

endmodule

// File: tb/tb_debug_op_sequencer.sv
// Scoreboard bench for debug_op_sequencer: directed ops push expected ACK/write results,
// a negedge monitor pops and compares whenever the DUT acknowledges or writes.
module tb_debug_op_sequencer;

    localparam logic [1:0] OP_STEP = 2'b00;
    localparam logic [1:0] OP_MRD  = 2'b01;
    localparam logic [1:0] OP_MWR  = 2'b10;
    localparam logic [1:0] OP_RUN  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [1:0]  debugx;
    logic        incx;
    logic        ack;
    logic        err;
    logic        err_clr;
    logic        addr_ld;
    logic [15:0] addr_in;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic [15:0] mem_addr;
    logic [15:0] mem_dout;
    logic [15:0] mem_din;
    logic        mem_rd;
    logic        mem_wr;
    logic        cpu_halt;
    logic        halted;
    logic        cpu_step;
    logic        step_done = 1'b0;

    always #5 clk = ~clk;

    debug_op_sequencer #(
        .AW(16), .DW(16), .MEM_LATENCY(2), .HALT_ON_RESET(1'b1), .TIMEOUT(255)
    ) dut (
        .CLK(clk), .RESET(rst), .DEBUG_REQ(req), .DEBUGX(debugx), .DEBUG_OP_INCX(incx),
        .DEBUG_ACK(ack), .DEBUG_ERR(err), .ERR_CLR(err_clr), .ADDR_LD(addr_ld),
        .ADDR_IN(addr_in), .WR_DATA(wr_data), .RD_DATA(rd_data), .MEM_ADDR(mem_addr),
        .MEM_DOUT(mem_dout), .MEM_DIN(mem_din), .MEM_RD(mem_rd), .MEM_WR(mem_wr),
        .CPU_HALT(cpu_halt), .CPU_HALTED(halted), .CPU_STEP(cpu_step),
        .CPU_STEP_DONE(step_done)
    );

    typedef struct packed {
        logic        err;
        logic [15:0] rd;
        logic [15:0] addr;
        logic        halt;
    } ack_exp_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_exp_t;

    ack_exp_t    ack_q[$];
    wr_exp_t     wr_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_seen = 0;
    int          wr_seen  = 0;
    int          step_seen = 0;
    int          rd_phase = 0;
    int          last_rd_len = 0;
    logic [15:0] rd_word = 16'h0000;
    logic        step_resp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic exp_ack(input logic e, input logic [15:0] rd, input logic [15:0] a,
                           input logic h);
        ack_exp_t x;
        x.err = e; x.rd = rd; x.addr = a; x.halt = h;
        ack_q.push_back(x);
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
        wr_exp_t x;
        x.addr = a; x.data = d;
        wr_q.push_back(x);
    endtask

    task automatic load_addr(input logic [15:0] a);
        @(posedge clk); #1;
        addr_ld = 1'b1; addr_in = a;
        @(posedge clk); #1;
        addr_ld = 1'b0;
    endtask

    // lat = negedges with ACK low, starting from the one before the request is sampled
    task automatic do_op(input logic [1:0] op, input logic inc, input int hold, output int lat);
        bit got = 0;
        @(posedge clk); #1;
        debugx = op; incx = inc; req = 1'b1;
        lat = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (i == 1) begin
                debugx = ~op; incx = ~inc;
            end
            if (ack) got = 1;
            else     lat++;
        end
        if (!got) check("ack_timeout", 32'(lat), 32'd0);
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    // Monitor: scoreboard compare on every ACK and MEM_WR cycle
    initial begin : monitor
        ack_exp_t ea;
        wr_exp_t  ew;
        forever begin
            @(negedge clk);
            if (ack === 1'b1) begin
                ack_seen++;
                if (ack_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL ack_unexpected: got ACK #%0d, required none", ack_seen);
                end else begin
                    ea = ack_q.pop_front();
                    check("ack_err",  32'(err),      32'(ea.err));
                    check("ack_rd",   32'(rd_data),  32'(ea.rd));
                    check("ack_addr", 32'(mem_addr), 32'(ea.addr));
                    check("ack_halt", 32'(cpu_halt), 32'(ea.halt));
                end
            end
            if (mem_wr === 1'b1) begin
                wr_seen++;
                if (wr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL wr_unexpected: got MEM_WR at %0h, required none", mem_addr);
                end else begin
                    ew = wr_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(ew.addr));
                    check("wr_data", 32'(mem_dout), 32'(ew.data));
                end
            end
            if (cpu_step === 1'b1) step_seen++;
        end
    end

    // Memory: valid data only on the final read-strobe cycle
    initial begin
        mem_din = 16'h0000;
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                rd_phase++;
                mem_din = (rd_phase == 2) ? rd_word : 16'hDEAD;
            end else begin
                if (rd_phase != 0) last_rd_len = rd_phase;
                rd_phase = 0;
            end
        end
    end

    // Core: step completes 4 clocks after the CPU_STEP pulse
    initial begin
        forever begin
            @(negedge clk);
            if (cpu_step === 1'b1 && step_resp) begin
                repeat (4) @(posedge clk);
                #1 step_done = 1'b1;
                @(posedge clk);
                #1 step_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat, acks0, steps0;
        bit seen;
        rst = 1'b1; req = 1'b0; debugx = 2'b00; incx = 1'b0; err_clr = 1'b0;
        addr_ld = 1'b0; addr_in = 16'h0000; wr_data = 16'h0000; halted = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_halt",  32'(cpu_halt), 32'd1);
        check("rst_ack",   32'(ack),      32'd0);
        check("rst_err",   32'(err),      32'd0);
        check("rst_rd",    32'(rd_data),  32'd0);
        check("rst_addr",  32'(mem_addr), 32'd0);
        check("rst_memrd", 32'(mem_rd),   32'd0);
        check("rst_memwr", 32'(mem_wr),   32'd0);
        check("rst_step",  32'(cpu_step), 32'd0);

        // Write with post-increment
        load_addr(16'h1234);
        wr_data = 16'hBEEF;
        exp_wr(16'h1234, 16'hBEEF);
        exp_ack(1'b0, 16'h0000, 16'h1235, 1'b1);
        do_op(OP_MWR, 1'b1, 0, lat);
        check("mwr_latency", 32'(lat), 32'd3);
        check("mwr_pulses", 32'(wr_seen), 32'd1);

        // Reads at the top of the address space
        load_addr(16'hFFFF);
        rd_word = 16'h00A5;
        exp_ack(1'b0, 16'h00A5, 16'hFFFF, 1'b1);
        do_op(OP_MRD, 1'b0, 0, lat);
        check("mrd_latency", 32'(lat), 32'd4);
        check("mrd_len", 32'(last_rd_len), 32'd2);
        rd_word = 16'h1357;
        last_rd_len = 0;
        exp_ack(1'b0, 16'h1357, 16'h0000, 1'b1);
        do_op(OP_MRD, 1'b1, 0, lat);
        check("mrd_wrap_len", 32'(last_rd_len), 32'd2);

        // Single step, then run
        step_resp = 1'b1;
        exp_ack(1'b0, 16'h1357, 16'h0000, 1'b1);
        do_op(OP_STEP, 1'b0, 0, lat);
        check("step_latency", 32'(lat), 32'd7);
        check("step_pulses", 32'(step_seen), 32'd1);
        exp_ack(1'b0, 16'h1357, 16'h0000, 1'b0);
        do_op(OP_RUN, 1'b0, 0, lat);
        check("run_latency", 32'(lat), 32'd1);
        @(negedge clk);
        check("run_halt", 32'(cpu_halt), 32'd0);

        // Core never halts: timeout
        halted = 1'b0;
        steps0 = step_seen;
        exp_ack(1'b1, 16'h1357, 16'h0000, 1'b1);
        do_op(OP_STEP, 1'b0, 0, lat);
        check("tmo_latency", 32'(lat), 32'd256);
        check("tmo_no_step", 32'(step_seen), 32'(steps0));
        @(negedge clk);
        check("tmo_err_sticky", 32'(err), 32'd1);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        check("err_clr", 32'(err), 32'd0);

        // Request held high after ACK runs only once
        halted = 1'b1;
        wr_data = 16'h4242;
        acks0 = ack_seen;
        exp_wr(16'h0000, 16'h4242);
        exp_ack(1'b0, 16'h1357, 16'h0000, 1'b1);
        do_op(OP_MWR, 1'b0, 10, lat);
        check("hold_one_ack", 32'(ack_seen - acks0), 32'd1);
        check("hold_one_wr", 32'(wr_seen), 32'd2);
        rd_word = 16'h2468;
        exp_ack(1'b0, 16'h2468, 16'h0001, 1'b1);
        do_op(OP_MRD, 1'b1, 0, lat);
        check("rereq_latency", 32'(lat), 32'd4);

        // Reset in the middle of a read
        acks0 = ack_seen;
        @(posedge clk); #1;
        debugx = OP_MRD; incx = 1'b0; req = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_rd) seen = 1;
        end
        check("abort_rd_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_memrd", 32'(mem_rd),   32'd0);
        check("abort_ack",   32'(ack),      32'd0);
        check("abort_addr",  32'(mem_addr), 32'd0);
        check("abort_rd",    32'(rd_data),  32'd0);
        check("abort_halt",  32'(cpu_halt), 32'd1);
        req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_ack", 32'(ack_seen - acks0), 32'd0);
        check("abort_idle_rd", 32'(mem_rd), 32'd0);
        check("sb_ack_empty", 32'(ack_q.size()), 32'd0);
        check("sb_wr_empty", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
